// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit scheduler
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        GAP   = 3'd5
    } tx_sched_state_t;

    // tx_done timeout window, in frame lengths (start + data + parity + stop)
    localparam int TIMEOUT_MULT = 2;

    function automatic int bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_cycle_timer.sv
// rtl/uart_cycle_timer.sv - loadable down-counter with a single expiry pulse
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_load         load i_load_val this cycle (wins over counting)
//   i_load_val     cycles from the load cycle to the expiry cycle
//   o_expire       high for the one cycle in which the count steps to zero
module uart_cycle_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    // Expiry lands load_val cycles after the load cycle, so a caller that
    // reacts at the end of the expiry cycle sees a window of load_val+1 cycles.
    assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - drains a read-latency-1 FIFO into the UART transmitter
// Optional feature macro: UART_TX_SCHED_CNT_EN adds the o_frame_cnt port.
// Ports:
//   i_clk, i_rst      clock, async active-high reset (released synchronously)
//   i_fifo_empty      FIFO empty flag, sampled only in IDLE
//   o_fifo_rd_en      one-cycle pop strobe per byte
//   i_fifo_dout       FIFO data, valid the cycle after a pop
//   o_tx_frame_en     one-cycle start strobe to the transmitter
//   o_tx_data         byte being sent, held until the next load
//   i_tx_done         transmitter end-of-frame pulse, honoured only in WAIT
//   i_cts             transmit permit, sampled only in IDLE
//   o_busy            high whenever the FSM is not IDLE
//   o_tx_err          sticky tx_done timeout flag
//   o_frame_cnt       frames completed by tx_done (macro builds only)
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int FRAME_WD      = 8,
    parameter int GAP_BITS      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd_en,
    input  logic [FRAME_WD-1:0] i_fifo_dout,
    output logic                o_tx_frame_en,
    output logic [FRAME_WD-1:0] o_tx_data,
    input  logic                i_tx_done,
    input  logic                i_cts,
    output logic                o_busy,
    output logic                o_tx_err
`ifdef UART_TX_SCHED_CNT_EN
    ,
    output logic [15:0]         o_frame_cnt
`endif
);

    localparam int BIT_CYC     = bit_cyc(CLK_FREQUENCE, BAUD_RATE);
    localparam int TIMEOUT_CYC = TIMEOUT_MULT * (FRAME_WD + 3) * BIT_CYC;
    localparam int GAP_CYC     = GAP_BITS * BIT_CYC;
    localparam int MAX_CYC     = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TW          = $clog2(MAX_CYC + 1);

    // Both windows include the cycle that loads the timer (START, or the
    // WAIT cycle that ends the frame), hence the minus one.
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD     = TW'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);
    // A gap of zero or one cycle never reaches a timer expiry; leave GAP at once.
    localparam bit            GAP_SHORT    = (GAP_CYC <= 1);

    tx_sched_state_t r_state;
    logic [1:0]      r_rst_pipe;
    logic            w_rst;
    logic            w_load;
    logic [TW-1:0]   w_load_val;
    logic            w_expire;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rst_pipe <= 2'b11;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b0};
        end
    end
    assign w_rst = r_rst_pipe[1];

    always_comb begin
        w_load     = 1'b0;
        w_load_val = TIMEOUT_LOAD;
        if (r_state == START) begin
            w_load = 1'b1;
        end else if (r_state == WAIT && (i_tx_done || w_expire)) begin
            w_load     = 1'b1;
            w_load_val = GAP_LOAD;
        end
    end

    uart_cycle_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (w_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state       <= IDLE;
            o_fifo_rd_en  <= 1'b0;
            o_tx_frame_en <= 1'b0;
            o_tx_data     <= '0;
            o_busy        <= 1'b0;
            o_tx_err      <= 1'b0;
`ifdef UART_TX_SCHED_CNT_EN
            o_frame_cnt   <= '0;
`endif
        end else begin
            o_fifo_rd_en  <= 1'b0;
            o_tx_frame_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!i_fifo_empty && i_cts) begin
                        r_state      <= POP;
                        o_fifo_rd_en <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                POP: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    o_tx_data     <= i_fifo_dout;
                    o_tx_frame_en <= 1'b1;
                    r_state       <= START;
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // tx_done takes priority over a simultaneous timeout
                    if (i_tx_done) begin
                        r_state     <= GAP;
`ifdef UART_TX_SCHED_CNT_EN
                        o_frame_cnt <= o_frame_cnt + 16'd1;
`endif
                    end else if (w_expire) begin
                        r_state  <= GAP;
                        o_tx_err <= 1'b1;
                    end
                end
                GAP: begin
                    if (GAP_SHORT || w_expire) begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       tx_frame_en;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       cts = 1'b0;
    logic       busy;
    logic       tx_err;
`ifdef UART_TX_SCHED_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] fifo_mem [0:15];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int bad_pop = 0;
    int fe_cnt  = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .CLK_FREQUENCE (1_000_000),
        .BAUD_RATE     (100_000),
        .FRAME_WD      (8),
        .GAP_BITS      (1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fifo_empty  (fifo_empty),
        .o_fifo_rd_en  (fifo_rd_en),
        .i_fifo_dout   (fifo_dout),
        .o_tx_frame_en (tx_frame_en),
        .o_tx_data     (tx_data),
        .i_tx_done     (tx_done),
        .i_cts         (cts),
        .o_busy        (busy),
        .o_tx_err      (tx_err)
`ifdef UART_TX_SCHED_CNT_EN
        ,
        .o_frame_cnt   (frame_cnt)
`endif
    );

    // Standard-read FIFO model: data appears the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) begin
                bad_pop <= bad_pop + 1;
            end else begin
                fifo_dout <= fifo_mem[rd_ptr[3:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_frame_en) fe_cnt <= fe_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fe(input int max, output int waited);
        waited = 0;
        while (tx_frame_en !== 1'b1 && waited < max) begin
            tick(1);
            waited++;
        end
    endtask

    int w;
    int seen;

    initial begin
        // Power-up reset state
        tick(4);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_frame_en", tx_frame_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_err", tx_err, 0);
`ifdef UART_TX_SCHED_CNT_EN
        chk("rst_frame_cnt", frame_cnt, 0);
`endif
        rst = 1'b0;
        tick(5);

        // Single byte A5
        cts = 1'b1;
        push(8'hA5);
        tick(1);
        chk("t2_rd_en_hi", fifo_rd_en, 1);
        chk("t2_busy", busy, 1);
        tick(1);
        chk("t2_rd_en_lo", fifo_rd_en, 0);
        chk("t2_fe_early", tx_frame_en, 0);
        tick(1);
        chk("t2_fe_hi", tx_frame_en, 1);
        chk("t2_data", tx_data, 8'hA5);
        tick(1);
        chk("t2_fe_lo", tx_frame_en, 0);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(8);
        chk("t2_busy_gap", busy, 1);
        tick(1);
        chk("t2_busy_drop", busy, 0);
        chk("t2_pops", rd_ptr, 1);

        // Mid-sim reset while idle with A5 held
        tick(5);
        chk("t1_data_held", tx_data, 8'hA5);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_data_clr", tx_data, 0);
        chk("t1_busy", busy, 0);
        chk("t1_rd_en", fifo_rd_en, 0);
        chk("t1_fe", tx_frame_en, 0);
`ifdef UART_TX_SCHED_CNT_EN
        chk("t1_frame_cnt", frame_cnt, 0);
`endif
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("t1_busy_after", busy, 0);
        chk("t1_no_strobe", fe_cnt, 1);

        // Three bytes, tx_done 50 cycles after each strobe
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_fe(20, w);
        chk("t3_latency", w, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_data", tx_data, i + 1);
            tick(50);
            tx_done = 1'b1;
            tick(1);
            tx_done = 1'b0;
            if (i < 2) begin
                wait_fe(100, w);
                chk("t3_spacing", 51 + w, 63);
            end
        end
        tick(12);
        chk("t3_idle", busy, 0);
        chk("t3_pops", rd_ptr, 4);
        chk("t3_strobes", fe_cnt, 4);
`ifdef UART_TX_SCHED_CNT_EN
        chk("t3_frame_cnt", frame_cnt, 3);
`endif

        // cts low holds off a non-empty FIFO
        cts = 1'b0;
        push(8'h3C);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (fifo_rd_en || busy) seen++;
        end
        chk("t4_hold", seen, 0);
        chk("t4_hold_pops", rd_ptr, 4);
        cts = 1'b1;
        tick(1);
        chk("t4_pop_next", fifo_rd_en, 1);
        tick(2);
        chk("t4_fe", tx_frame_en, 1);
        chk("t4_data", tx_data, 8'h3C);
        tick(1);
        cts = 1'b0;
        push(8'h7E);
        tick(10);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(40);
        chk("t4_no_next_pop", rd_ptr, 5);
        chk("t4_idle", busy, 0);
        chk("t4_data_held", tx_data, 8'h3C);
        // tx_done while idle is ignored
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(3);
        chk("t4_stray_done", busy, 0);
`ifdef UART_TX_SCHED_CNT_EN
        chk("t4_frame_cnt", frame_cnt, 4);
`endif

        // tx_done in the same cycle as the timeout expiry counts as done
        cts = 1'b1;
        wait_fe(20, w);
        chk("t5a_latency", w, 3);
        chk("t5a_data", tx_data, 8'h7E);
        cts = 1'b0;
        tick(219);
        chk("t5a_err_pre", tx_err, 0);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("t5a_err_tie", tx_err, 0);
        chk("t5a_busy", busy, 1);
`ifdef UART_TX_SCHED_CNT_EN
        chk("t5a_frame_cnt", frame_cnt, 5);
`endif
        tick(20);

        // tx_done never arrives
        push(8'h5A);
        cts = 1'b1;
        wait_fe(20, w);
        chk("t5_data", tx_data, 8'h5A);
        cts = 1'b0;
        tick(219);
        chk("t5_err_pre", tx_err, 0);
        tick(1);
        chk("t5_err_set", tx_err, 1);
        chk("t5_busy_gap", busy, 1);
        tick(8);
        chk("t5_busy_end_gap", busy, 1);
        tick(1);
        chk("t5_idle", busy, 0);
        tick(50);
        chk("t5_err_sticky", tx_err, 1);
`ifdef UART_TX_SCHED_CNT_EN
        chk("t5_no_count", frame_cnt, 5);
`endif

        // Reset during WAIT discards the in-flight byte
        cts = 1'b1;
        push(8'h99);
        wait_fe(20, w);
        chk("t6_data", tx_data, 8'h99);
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_err_clr", tx_err, 0);
        chk("t6_data_clr", tx_data, 0);
`ifdef UART_TX_SCHED_CNT_EN
        chk("t6_frame_cnt", frame_cnt, 0);
`endif
        @(posedge clk);
        #1;
        tick(1);
        rst = 1'b0;
        tick(100);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(200);
        chk("t6_no_strobe", fe_cnt, 8);
        chk("t6_no_pop", rd_ptr, 8);
        chk("t6_idle", busy, 0);
        push(8'h42);
        wait_fe(20, w);
        chk("t6_new_latency", w, 3);
        chk("t6_new_data", tx_data, 8'h42);
        chk("no_empty_pop", bad_pop, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
